// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between the requesting engines and the register-bank arbiter.
// The master side raises requests and clear pulses; the slave side issues acks and bank strobes.
interface reg_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*8-1:0]  req_data;
    logic               clear_all;
    logic [NREQ-1:0]    ack;
    logic [NREGS-1:0]   load;
    logic [7:0]         d;
    logic               busy;

    modport master (
        output req, req_addr, req_data, clear_all,
        input  ack, load, d, busy
    );

    modport slave (
        input  req, req_addr, req_data, clear_all,
        output ack, load, d, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for an 8-bit register bank, with a one-register-per-cycle
// clear-all sweep. Every output is registered.
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_write_arbiter_if.slave    bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [AW-1:0]    clr_cnt_q;
    logic [NREQ-1:0]  ack_q;
    logic [NREGS-1:0] load_q;
    logic [7:0]       d_q;
    logic             busy_q;

    logic [AW-1:0]    addr_arr [NREQ];
    logic [7:0]       data_arr [NREQ];
    logic [NREGS-1:0] dec_arr  [NREQ];

    // Out-of-range addresses decode to no strobe, so the write is acked but dropped.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
        assign data_arr[gi] = bus.req_data[gi*8 +: 8];
        assign dec_arr[gi]  = (int'(addr_arr[gi]) < NREGS) ? (NREGS'(1) << addr_arr[gi]) : '0;
    end

    logic [NREQ-1:0] eligible;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     scan_sum;
    logic [PW:0]     win_inc;
    logic [PW-1:0]   win_ptr_next;

    // The requester acked this cycle is masked so a held req cannot win twice in a row.
    assign eligible = bus.req & ~ack_q;

    // Scan from the farthest offset down so the closest eligible index to rr_ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(off);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            if (eligible[scan_sum[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = scan_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        win_inc      = {1'b0, win_idx} + 1'b1;
        win_ptr_next = (win_inc == (PW+1)'(NREQ)) ? '0 : win_inc[PW-1:0];
    end

    logic start_clear;
    logic clear_step;

    assign start_clear = (state_q == ARB) && bus.clear_all;
    assign clear_step  = (state_q == CLEAR) && (clr_cnt_q != AW'(NREGS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            clr_cnt_q <= '0;
            ack_q     <= '0;
            load_q    <= '0;
            d_q       <= 8'h00;
            busy_q    <= 1'b0;
        end else if (start_clear) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ack_q     <= '0;
            load_q    <= NREGS'(1);
            d_q       <= 8'h00;
            busy_q    <= 1'b1;
        end else if (clear_step) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            load_q    <= NREGS'(1) << (clr_cnt_q + 1'b1);
        end else begin
            // Normal arbitration, also taken on the edge that ends the last clear strobe.
            state_q   <= ARB;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            if (win_valid) begin
                ack_q    <= NREQ'(1) << win_idx;
                load_q   <= dec_arr[win_idx];
                d_q      <= data_arr[win_idx];
                rr_ptr_q <= win_ptr_next;
            end else begin
                ack_q  <= '0;
                load_q <= '0;
            end
        end
    end

    assign bus.ack  = ack_q;
    assign bus.load = load_q;
    assign bus.d    = d_q;
    assign bus.busy = busy_q;
endmodule
